i2c_phy_gen3: RTL and testbench

I2C_PHY_GEN3 -- requirements
Module: i2c_phy_gen3

---
 rtl/i2c_phy_gen3.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_phy_gen3.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_phy_gen3.sv
// I2C master bit/byte engine: START, STOP, WRITE and READ over open-drain SCL/SDA.
// Optional SCL clock stretching with timeout when I2C_CLK_STRETCH_EN is defined.
`timescale 1ns/1ps
module i2c_phy_gen3 #(
  parameter int DIV_W = 16,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [TMO_W-1:0] stretch_limit,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       data_from_master,
  input  logic             master_ack,
  output logic             done,
  output logic             slave_ack,
  output logic [7:0]       data_from_slave,
  output logic             arb_lost,
  output logic             timeout,
  output logic             bus_busy,
  inout  wire              i2c_scl,
  inout  wire              i2c_sda
);

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_XFER, S_STRETCH} state_t;

  state_t           r_state, w_nxt, r_ret, w_run;
  logic             r_init;
  logic [DIV_W-1:0] r_qcnt;
  logic [1:0]       r_q;
  logic [3:0]       r_bit;
  logic [7:0]       r_tx, r_sh, r_rx;
  logic             r_rd, r_mack, r_sack, r_arb, r_tmo, r_busy, r_done;
  logic             r_scl_low, r_sda_low;
  logic [TMO_W-1:0] r_stcnt;

  logic w_qend, w_accept, w_scl_in, w_sda_in, w_str_en, w_arb, w_q2_sda, w_q0_sda;

`ifdef I2C_CLK_STRETCH_EN
  assign w_str_en = 1'b1;
  assign w_scl_in = i2c_scl;
  assign timeout  = r_tmo;
`else
  logic w_unused_tmo;
  assign w_str_en     = 1'b0;
  assign w_scl_in     = 1'b1;
  assign timeout      = 1'b0;
  assign w_unused_tmo = r_tmo;
`endif

  assign i2c_scl  = r_scl_low ? 1'b0 : 1'bz;
  assign i2c_sda  = r_sda_low ? 1'b0 : 1'bz;
  assign w_sda_in = i2c_sda;

  assign cmd_ready       = r_init && (r_state == S_IDLE);
  assign w_accept        = cmd_valid && cmd_ready;
  assign done            = r_done;
  assign slave_ack       = r_sack;
  assign data_from_slave = r_rx;
  assign arb_lost        = r_arb;
  assign bus_busy        = r_busy;

  assign w_qend = (r_qcnt == clk_div);
  // A released '1' that reads back as '0' means another master owns the bus.
  assign w_arb  = (r_state == S_XFER) && !r_rd && (r_bit != 4'd8) && r_tx[7] && !w_sda_in;

  // Q2 line action is shared between normal flow and resumption from a stretch.
  assign w_run    = (r_state == S_STRETCH) ? r_ret : r_state;
  assign w_q2_sda = (w_run == S_START) ? 1'b1 : (w_run == S_STOP) ? 1'b0 : r_sda_low;
  assign w_q0_sda = r_rd ? ((r_bit == 4'd7) && r_mack) : ((r_bit != 4'd7) && !r_tx[6]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd == C_START)     w_nxt = S_START;
          else if (cmd == C_STOP) w_nxt = S_STOP;
          else                    w_nxt = S_XFER;
        end
      end
      S_START, S_STOP, S_XFER: begin
        if (w_qend) begin
          if ((r_q == 2'd1) && w_str_en && !w_scl_in)                      w_nxt = S_STRETCH;
          else if ((r_q == 2'd2) && w_arb)                                 w_nxt = S_IDLE;
          else if ((r_q == 2'd3) && ((r_state != S_XFER) || (r_bit == 4'd8))) w_nxt = S_IDLE;
        end
      end
      S_STRETCH: begin
        if (w_scl_in)                              w_nxt = r_ret;
        else if (w_qend && (r_stcnt == stretch_limit)) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init    <= 1'b0;
      r_qcnt    <= '0;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_tx      <= 8'h00;
      r_sh      <= 8'h00;
      r_rx      <= 8'h00;
      r_rd      <= 1'b0;
      r_mack    <= 1'b0;
      r_sack    <= 1'b0;
      r_arb     <= 1'b0;
      r_tmo     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_stcnt   <= '0;
      r_ret     <= S_IDLE;
    end else begin
      r_init <= 1'b1;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_qcnt  <= '0;
            r_q     <= 2'd0;
            r_bit   <= 4'd0;
            r_stcnt <= '0;
            r_tx    <= data_from_master;
            r_mack  <= master_ack;
            r_rd    <= (cmd == C_READ);
            r_sh    <= 8'h00;
            r_rx    <= 8'h00;
            r_sack  <= 1'b0;
            r_arb   <= 1'b0;
            r_tmo   <= 1'b0;
            // Q0 line action takes effect on the acceptance edge.
            unique case (cmd)
              C_START: r_sda_low <= 1'b0;
              C_STOP:  r_sda_low <= 1'b1;
              C_WRITE: r_sda_low <= ~data_from_master[7];
              default: r_sda_low <= 1'b0;
            endcase
          end
        end
        S_START, S_STOP, S_XFER: begin
          if (!w_qend) begin
            r_qcnt <= r_qcnt + DIV_W'(1);
          end else begin
            r_qcnt <= '0;
            unique case (r_q)
              2'd0: begin
                r_q       <= 2'd1;
                r_scl_low <= 1'b0;
              end
              2'd1: begin
                if (w_str_en && !w_scl_in) begin
                  r_ret   <= r_state;
                  r_stcnt <= '0;
                end else begin
                  r_q       <= 2'd2;
                  r_sda_low <= w_q2_sda;
                end
              end
              2'd2: begin
                if (r_state == S_XFER) begin
                  if (r_rd && (r_bit != 4'd8)) r_sh   <= {r_sh[6:0], w_sda_in};
                  if (!r_rd && (r_bit == 4'd8)) r_sack <= !w_sda_in;
                end
                if (w_arb) begin
                  r_arb     <= 1'b1;
                  r_scl_low <= 1'b0;
                  r_sda_low <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                end else begin
                  r_q <= 2'd3;
                  if (r_state != S_STOP) r_scl_low <= 1'b1;
                end
              end
              default: begin
                if ((r_state == S_XFER) && (r_bit != 4'd8)) begin
                  r_q       <= 2'd0;
                  r_bit     <= r_bit + 4'd1;
                  r_tx      <= {r_tx[6:0], 1'b0};
                  r_sda_low <= w_q0_sda;
                end else begin
                  r_done <= 1'b1;
                  if (r_state == S_START) r_busy <= 1'b1;
                  if (r_state == S_STOP)  r_busy <= 1'b0;
                  if (r_state == S_XFER) begin
                    r_sda_low <= 1'b0;
                    if (r_rd) r_rx <= r_sh;
                  end
                end
              end
            endcase
          end
        end
        S_STRETCH: begin
          if (w_scl_in) begin
            r_q       <= 2'd2;
            r_qcnt    <= '0;
            r_sda_low <= w_q2_sda;
          end else if (!w_qend) begin
            r_qcnt <= r_qcnt + DIV_W'(1);
          end else begin
            r_qcnt <= '0;
            if (r_stcnt == stretch_limit) begin
              r_tmo     <= 1'b1;
              r_scl_low <= 1'b0;
              r_sda_low <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_stcnt <= r_stcnt + TMO_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_phy_gen3.sv
// Directed bench for i2c_phy_gen3: reset, START/WRITE/READ/STOP, repeated start,
// pending command, arbitration loss, reset mid-command, optional clock stretching.
`timescale 1ns/1ps
module tb_i2c_phy_gen3;
  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clk_div = 16'd4;
  logic [15:0] stretch_limit = 16'd10;
  logic [1:0]  cmd = 2'd0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  dfm = 8'h00;
  logic        mack = 1'b0;
  wire         cmd_ready, done, slave_ack, arb_lost, timeout, bus_busy;
  wire  [7:0]  dfs;
  wire         scl, sda;

  pullup (scl);
  pullup (sda);

  logic slv_sda_low, slv_scl_low = 1'b0;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;
  assign scl = slv_scl_low ? 1'b0 : 1'bz;

  i2c_phy_gen3 #(.DIV_W(16), .TMO_W(16)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .stretch_limit(stretch_limit),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_from_master(dfm), .master_ack(mack), .done(done), .slave_ack(slave_ack),
    .data_from_slave(dfs), .arb_lost(arb_lost), .timeout(timeout), .bus_busy(bus_busy),
    .i2c_scl(scl), .i2c_sda(sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Slave model: SDA changes only on SCL falls, counted relative to fbase.
  int nfall = 0, fbase = 0, slv_mode = 0;
  logic [7:0] slv_byte = 8'h00;
  always @(negedge scl) nfall = nfall + 1;
  always_comb begin
    int k;
    logic [7:0] shb;
    k = nfall - fbase;
    shb = slv_byte << k[3:0];
    slv_sda_low = 1'b0;
    case (slv_mode)
      1: slv_sda_low = (k == 8);
      2: slv_sda_low = (k < 8) ? ~shb[7] : 1'b0;
      3: slv_sda_low = (k >= 2);
      default: slv_sda_low = 1'b0;
    endcase
  end

  // Bus monitor: START/STOP conditions and the last nine SDA samples at SCL rise.
  int nstart = 0, nstop = 0;
  logic [8:0] samp = 9'h000;
  always @(negedge sda) if (scl === 1'b1) nstart = nstart + 1;
  always @(posedge sda) if (scl === 1'b1) nstop = nstop + 1;
  always @(posedge scl) samp = {samp[7:0], sda};

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic m, output int t0);
    int n;
    n = 0;
    @(negedge clk);
    cmd = c; dfm = d; mack = m; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL issue_ready got=%b want=1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_done got=timeout want=done");
    end
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, done, bus_busy, slave_ack, arb_lost, timeout, dfs} !== 14'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
                      {cmd_ready, done, bus_busy, slave_ack, arb_lost, timeout, dfs});
    end
    total++;
    if ({scl, sda} !== 2'b11) begin bad++; $display("FAIL reset_lines got=%b want=11", {scl, sda}); end
    rst = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_pre got=%b want=0", cmd_ready); end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_post got=%b want=1", cmd_ready); end
  endtask

  task automatic test_start_write();
    int t0, lat, s0, p0;
    clk_div = 16'd4;
    slv_mode = 0;
    s0 = nstart;
    issue(C_START, 8'h00, 1'b0, t0);
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL start_ready_busy got=%b want=0", cmd_ready); end
    wait_done(t0, lat);
    total++;
    if (lat !== 20) begin bad++; $display("FAIL start_latency got=%0d want=20", lat); end
    total++;
    if (nstart !== s0 + 1) begin bad++; $display("FAIL start_cond got=%0d want=%0d", nstart, s0 + 1); end
    @(negedge clk);
    total++;
    if ({done, bus_busy} !== 2'b01) begin bad++; $display("FAIL start_busy got=%b want=01", {done, bus_busy}); end

    fbase = nfall; slv_mode = 1;
    s0 = nstart; p0 = nstop;
    issue(C_WRITE, 8'hA5, 1'b0, t0);
    wait_done(t0, lat);
    total++;
    if (lat !== 180) begin bad++; $display("FAIL write_latency got=%0d want=180", lat); end
    total++;
    if (slave_ack !== 1'b1) begin bad++; $display("FAIL write_ack got=%b want=1", slave_ack); end
    total++;
    if (samp !== 9'h14A) begin bad++; $display("FAIL write_bits got=%h want=14a", samp); end
    total++;
    if ({nstart, nstop} !== {s0, p0}) begin
      bad++; $display("FAIL write_sda_stable got=%0d/%0d want=%0d/%0d", nstart, nstop, s0, p0);
    end
    @(negedge clk);
    total++;
    if ({done, scl, sda} !== 3'b001) begin bad++; $display("FAIL write_end got=%b want=001", {done, scl, sda}); end
    slv_mode = 0;
  endtask

  task automatic test_read();
    int t0, lat;
    slv_byte = 8'h3C; fbase = nfall; slv_mode = 2;
    issue(C_READ, 8'h00, 1'b0, t0);
    total++;
    if (slave_ack !== 1'b0) begin bad++; $display("FAIL read_ack_clear got=%b want=0", slave_ack); end
    wait_done(t0, lat);
    total++;
    if (lat !== 180) begin bad++; $display("FAIL read_latency got=%0d want=180", lat); end
    total++;
    if (dfs !== 8'h3C) begin bad++; $display("FAIL read_data got=%h want=3c", dfs); end
    total++;
    if (samp !== 9'h079) begin bad++; $display("FAIL read_bits got=%h want=079", samp); end
    @(negedge clk);
    total++;
    if ({done, sda, dfs} !== {2'b01, 8'h3C}) begin
      bad++; $display("FAIL read_hold got=%h want=13c", {done, sda, dfs});
    end
    slv_mode = 0;
  endtask

  task automatic test_repeated_stop();
    int t0, lat, s0, p0;
    s0 = nstart; p0 = nstop;
    issue(C_START, 8'h00, 1'b0, t0);
    total++;
    if (dfs !== 8'h00) begin bad++; $display("FAIL rstart_clear_data got=%h want=00", dfs); end
    wait_done(t0, lat);
    total++;
    if ({nstart, nstop, bus_busy} !== {s0 + 1, p0, 1'b1}) begin
      bad++; $display("FAIL rstart_cond got=%0d/%0d/%b want=%0d/%0d/1", nstart, nstop, bus_busy, s0 + 1, p0);
    end
    issue(C_STOP, 8'h00, 1'b0, t0);
    total++;
    if (bus_busy !== 1'b1) begin bad++; $display("FAIL stop_busy_during got=%b want=1", bus_busy); end
    wait_done(t0, lat);
    total++;
    if (lat !== 20) begin bad++; $display("FAIL stop_latency got=%0d want=20", lat); end
    total++;
    if ({bus_busy, nstop, scl, sda} !== {1'b0, p0 + 1, 2'b11}) begin
      bad++; $display("FAIL stop_end got=%b/%0d/%b%b want=0/%0d/11", bus_busy, nstop, scl, sda, p0 + 1);
    end
  endtask

  task automatic test_pending_arb();
    int t0, lat, n;
    n = 0;
    @(negedge clk);
    cmd = C_START; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    cmd = C_WRITE; dfm = 8'hFF; mack = 1'b0;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL pending_ready got=%b want=0", cmd_ready); end
    wait_done(t0, lat);
    total++;
    if ({lat, cmd_ready} !== {32'd20, 1'b1}) begin
      bad++; $display("FAIL pending_accept got=%0d/%b want=20/1", lat, cmd_ready);
    end
    fbase = nfall; slv_mode = 3;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    cmd_valid = 1'b0;
    wait_done(t0, lat);
    total++;
    if (lat !== 55) begin bad++; $display("FAIL arb_latency got=%0d want=55", lat); end
    total++;
    if ({arb_lost, bus_busy, scl} !== 3'b101) begin
      bad++; $display("FAIL arb_state got=%b want=101", {arb_lost, bus_busy, scl});
    end
    slv_mode = 0;
    @(negedge clk);
    total++;
    if ({done, scl, sda} !== 3'b011) begin bad++; $display("FAIL arb_release got=%b want=011", {done, scl, sda}); end
  endtask

  task automatic test_reset_mid();
    int t0, lat;
    logic saw;
    saw = 1'b0;
    issue(C_START, 8'h00, 1'b0, t0);
    wait_done(t0, lat);
    issue(C_WRITE, 8'h00, 1'b0, t0);
    repeat (42) @(negedge clk);
    total++;
    if ({scl, sda} !== 2'b00) begin bad++; $display("FAIL rmid_pre got=%b want=00", {scl, sda}); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({scl, sda, bus_busy, cmd_ready} !== 4'b1100) begin
      bad++; $display("FAIL rmid_async got=%b want=1100", {scl, sda, bus_busy, cmd_ready});
    end
    repeat (5) begin @(negedge clk); if (done) saw = 1'b1; end
    rst = 1'b1;
    #1;
    if (done) saw = 1'b1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_pre got=%b want=0", cmd_ready); end
    @(negedge clk);
    if (done) saw = 1'b1;
    total++;
    if ({cmd_ready, saw} !== 2'b10) begin bad++; $display("FAIL rmid_ready_nodone got=%b want=10", {cmd_ready, saw}); end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int t0, lat, n;
    logic saw;
    clk_div = 16'd1; stretch_limit = 16'd10;
    issue(C_START, 8'h00, 1'b0, t0);
    wait_done(t0, lat);
    for (int h = 0; h < 2; h++) begin
      saw = 1'b0; n = 0;
      fbase = nfall;
      issue(C_WRITE, 8'h00, 1'b0, t0);
      while (nfall - fbase < 3 && n < 500) begin @(negedge clk); n++; end
      slv_scl_low = 1'b1;
      repeat (h == 0 ? 14 : 40) begin @(negedge clk); if (done) saw = 1'b1; end
      slv_scl_low = 1'b0;
      if (h == 0) begin
        wait_done(t0, lat);
        total++;
        if (timeout !== 1'b0 || lat <= 72 || lat > 86) begin
          bad++; $display("FAIL stretch_ok got=%b/%0d want=0/73..86", timeout, lat);
        end
      end else begin
        @(negedge clk);
        total++;
        if ({saw, timeout, bus_busy, scl, sda} !== 5'b11011) begin
          bad++; $display("FAIL stretch_tmo got=%b want=11011", {saw, timeout, bus_busy, scl, sda});
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_write();
    test_read();
    test_repeated_stop();
    test_pending_arb();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
